// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-bit positions, MEM-stage FSM states, word width.
package mips_pkg;
  localparam int WORD_W = 32;

  // M control bit positions
  localparam int M_BRANCH = 2;
  localparam int M_READ   = 1;
  localparam int M_WRITE  = 0;

  // WB control bit positions
  localparam int WB_MEM2REG  = 1;
  localparam int WB_REGWRITE = 0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;
endpackage

// File: rtl/data_memory.sv
// Data memory: DEPTH x 32 words, synchronous write, combinational read.
// The array is deliberately not reset.
module data_memory
  import mips_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];

  // store commits on the rising edge
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  // read returns the pre-write word during a same-cycle store
  assign rdata = mem[idx];
endmodule

// File: rtl/mem_access.sv
// MEM stage: data-memory access, branch resolve, MEM/WB register.
// MEM_LATENCY>0 enables a wait-state FSM that stalls upstream for N cycles per access.
// Optional macro MISALIGN_EN: adds the misaligned output; accesses with res[1:0]!=0
// are suppressed and their register write is cancelled.
module mem_access
  import mips_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] res,
  input  logic [31:0] write_data_ex,
  input  logic [4:0]  write_register,
  input  logic [2:0]  m_MEM,
  input  logic [1:0]  wb_MEM,
  input  logic        zero,
  output logic [31:0] read_data,
  output logic [31:0] alu_res_wb,
  output logic [4:0]  write_register_wb,
  output logic [1:0]  wb_WB,
  output logic        pc_src,
  output logic        stall
`ifdef MISALIGN_EN
  ,
  output logic        misaligned
`endif
);
  localparam int CNT_W = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (MEM_LATENCY > 0) ? CNT_W'(MEM_LATENCY - 1) : '0;

  mem_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rdata;
  logic              access, bad, we;

  assign idx    = res[ADDR_W+1:2];
  assign access = m_MEM[M_READ] | m_MEM[M_WRITE];

`ifdef MISALIGN_EN
  assign bad = access & (res[1:0] != 2'b00);
`else
  assign bad = 1'b0;
`endif

  // the access only takes effect in the cycle stall is low (completing cycle)
  assign we     = ~stall & m_MEM[M_WRITE] & ~bad;
  assign pc_src = m_MEM[M_BRANCH] & zero & ~stall;

  data_memory #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dmem (
    .clk   (clk),
    .we    (we),
    .idx   (idx),
    .wdata (write_data_ex),
    .rdata (rdata)
  );

  // FSM state and wait counter; reset aborts any pending access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // next state: each access gets a fresh N-cycle wait
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (MEM_LATENCY > 0) begin
      case (state)
        IDLE: if (access) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_INIT;
        end
        WAIT: if (cnt != '0) cnt_nxt = cnt - 1'b1;
              else           state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // stall output: held while the access is still waiting
  always_comb begin
    stall = 1'b0;
    if (MEM_LATENCY > 0) begin
      case (state)
        IDLE:    stall = access;
        WAIT:    stall = (cnt != '0);
        default: stall = 1'b0;
      endcase
    end
  end

  // MEM/WB register: bubble while stalled, capture otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data         <= '0;
      alu_res_wb        <= '0;
      write_register_wb <= '0;
      wb_WB             <= '0;
`ifdef MISALIGN_EN
      misaligned        <= 1'b0;
`endif
    end else if (stall) begin
      read_data         <= '0;
      alu_res_wb        <= '0;
      write_register_wb <= '0;
      wb_WB             <= '0;
`ifdef MISALIGN_EN
      misaligned        <= 1'b0;
`endif
    end else begin
      read_data         <= (m_MEM[M_READ] & ~bad) ? rdata : '0;
      alu_res_wb        <= res;
      write_register_wb <= write_register;
      wb_WB             <= {wb_MEM[WB_MEM2REG], wb_MEM[WB_REGWRITE] & ~bad};
`ifdef MISALIGN_EN
      misaligned        <= bad;
`endif
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: one single-cycle instance and one MEM_LATENCY=3 instance.
// Honours MISALIGN_EN when defined.
module tb_mem_access;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // single-cycle instance
  logic        rst0;
  logic [31:0] res0, wd0, rd0, alu0;
  logic [4:0]  wr0, wrwb0;
  logic [2:0]  m0;
  logic [1:0]  wb0, wbwb0;
  logic        z0, pc0, st0;
  // latency-3 instance
  logic        rst3;
  logic [31:0] res3, wd3, rd3, alu3;
  logic [4:0]  wr3, wrwb3;
  logic [2:0]  m3;
  logic [1:0]  wb3, wbwb3;
  logic        z3, pc3, st3;
`ifdef MISALIGN_EN
  logic        mis0, mis3;
`endif

  mem_access #(.DEPTH(256), .ADDR_W(8), .MEM_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst0), .res(res0), .write_data_ex(wd0), .write_register(wr0),
    .m_MEM(m0), .wb_MEM(wb0), .zero(z0), .read_data(rd0), .alu_res_wb(alu0),
    .write_register_wb(wrwb0), .wb_WB(wbwb0), .pc_src(pc0), .stall(st0)
`ifdef MISALIGN_EN
    , .misaligned(mis0)
`endif
  );

  mem_access #(.DEPTH(256), .ADDR_W(8), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst3), .res(res3), .write_data_ex(wd3), .write_register(wr3),
    .m_MEM(m3), .wb_MEM(wb3), .zero(z3), .read_data(rd3), .alu_res_wb(alu3),
    .write_register_wb(wrwb3), .wb_WB(wbwb3), .pc_src(pc3), .stall(st3)
`ifdef MISALIGN_EN
    , .misaligned(mis3)
`endif
  );

  // reference memories: word-addressed, index = (byte address / 4) mod 256
  logic [31:0] ref0 [256];
  logic [31:0] ref3 [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // behavioural model of one completed access; updates the reference memory
  function automatic void model(input int u, input logic [31:0] res, input logic [31:0] wd,
                                input logic [2:0] m, input logic [1:0] wb,
                                output logic [31:0] erd, output logic [1:0] ewb,
                                output logic emis);
    int i;
    bit bad;
    logic [31:0] old;
    i   = int'((res / 4) % 256);
    bad = 0;
`ifdef MISALIGN_EN
    bad = (m[1] || m[0]) && (res % 4 != 0);
`endif
    old  = (u != 0) ? ref3[i] : ref0[i];
    erd  = (m[1] && !bad) ? old : 32'h0;
    ewb  = bad ? {wb[1], 1'b0} : wb;
    emis = bad;
    if (m[0] && !bad) begin
      if (u != 0) ref3[i] = wd;
      else        ref0[i] = wd;
    end
  endfunction

  task automatic drive0(input logic [31:0] r, input logic [31:0] d, input logic [4:0] w,
                        input logic [2:0] m, input logic [1:0] b, input logic z);
    res0 = r; wd0 = d; wr0 = w; m0 = m; wb0 = b; z0 = z;
  endtask

  task automatic drive3(input logic [31:0] r, input logic [31:0] d, input logic [4:0] w,
                        input logic [2:0] m, input logic [1:0] b, input logic z);
    res3 = r; wd3 = d; wr3 = w; m3 = m; wb3 = b; z3 = z;
  endtask

  // one single-cycle operation checked against the model
  task automatic op0(input logic [31:0] r, input logic [31:0] d, input logic [4:0] w,
                     input logic [2:0] m, input logic [1:0] b, input logic z);
    logic [31:0] erd;
    logic [1:0]  ewb;
    logic        emis;
    model(0, r, d, m, b, erd, ewb, emis);
    drive0(r, d, w, m, b, z);
    #1;
    chk("l0_pc_src", {31'b0, pc0}, {31'b0, m[2] & z});
    chk("l0_stall", {31'b0, st0}, 32'h0);
    @(posedge clk); #1;
    chk("l0_read_data", rd0, erd);
    chk("l0_wb_WB", {30'b0, wbwb0}, {30'b0, ewb});
    chk("l0_alu_res_wb", alu0, r);
    chk("l0_wreg_wb", {27'b0, wrwb0}, {27'b0, w});
`ifdef MISALIGN_EN
    chk("l0_misaligned", {31'b0, mis0}, {31'b0, emis});
`endif
  endtask

  // one latency-3 transaction held until it completes
  task automatic txn3(input logic [31:0] r, input logic [31:0] d, input logic [4:0] w,
                      input logic [2:0] m, input logic [1:0] b, input logic z);
    logic [31:0] erd;
    logic [1:0]  ewb;
    logic        emis;
    int stalls;
    model(1, r, d, m, b, erd, ewb, emis);
    drive3(r, d, w, m, b, z);
    #1;
    stalls = 0;
    while (st3 === 1'b1 && stalls < 10) begin
      chk("l3_pc_src_stalled", {31'b0, pc3}, 32'h0);
      @(posedge clk); #1;
      stalls++;
      chk("l3_bubble_wb", {30'b0, wbwb3}, 32'h0);
      chk("l3_bubble_rd", rd3, 32'h0);
      chk("l3_bubble_alu", alu3, 32'h0);
      chk("l3_bubble_wreg", {27'b0, wrwb3}, 32'h0);
    end
    chk("l3_stall_cycles", stalls, (m[1] || m[0]) ? 32'd3 : 32'd0);
    chk("l3_pc_src", {31'b0, pc3}, {31'b0, m[2] & z});
    @(posedge clk); #1;
    chk("l3_read_data", rd3, erd);
    chk("l3_wb_WB", {30'b0, wbwb3}, {30'b0, ewb});
    chk("l3_alu_res_wb", alu3, r);
    chk("l3_wreg_wb", {27'b0, wrwb3}, {27'b0, w});
`ifdef MISALIGN_EN
    chk("l3_misaligned", {31'b0, mis3}, {31'b0, emis});
`endif
  endtask

  typedef struct {
    logic [31:0] res;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic [2:0]  m;
    logic [1:0]  wb;
    logic        z;
    logic [31:0] e_rd;
    logic [1:0]  e_wb;
    logic        e_pc;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] erd, old;
    logic [1:0]  ewb;
    logic        emis;
    logic [31:0] r;

    vecs[0] = '{32'h10,  32'hDEADBEEF, 5'd0, 3'b001, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0};
    vecs[1] = '{32'h10,  32'h0,        5'd5, 3'b010, 2'b11, 1'b0, 32'hDEADBEEF, 2'b11, 1'b0};
    vecs[2] = '{32'h55,  32'h0,        5'd7, 3'b000, 2'b01, 1'b0, 32'h0,        2'b01, 1'b0};
    vecs[3] = '{32'h0,   32'h0,        5'd0, 3'b100, 2'b00, 1'b1, 32'h0,        2'b00, 1'b1};
    vecs[4] = '{32'h0,   32'h0,        5'd0, 3'b100, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0};
    vecs[5] = '{32'h400, 32'h12345678, 5'd0, 3'b001, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0};
    vecs[6] = '{32'h0,   32'h0,        5'd9, 3'b010, 2'b11, 1'b0, 32'h12345678, 2'b11, 1'b0};
    vecs[7] = '{32'h20,  32'hAAAA5555, 5'd0, 3'b001, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0};
    vecs[8] = '{32'h20,  32'h0BADF00D, 5'd3, 3'b011, 2'b11, 1'b0, 32'hAAAA5555, 2'b11, 1'b0};
    vecs[9] = '{32'h20,  32'h0,        5'd4, 3'b010, 2'b11, 1'b0, 32'h0BADF00D, 2'b11, 1'b0};

    rst0 = 1'b1; rst3 = 1'b1;
    drive0('0, '0, '0, '0, '0, 1'b0);
    drive3('0, '0, '0, '0, '0, 1'b0);
    #12;
    chk("rst_rd0", rd0, 32'h0);
    chk("rst_alu0", alu0, 32'h0);
    chk("rst_wb0", {30'b0, wbwb0}, 32'h0);
    chk("rst_wreg0", {27'b0, wrwb0}, 32'h0);
    chk("rst_rd3", rd3, 32'h0);
    chk("rst_wb3", {30'b0, wbwb3}, 32'h0);
    chk("rst_stall3", {31'b0, st3}, 32'h0);
`ifdef MISALIGN_EN
    chk("rst_mis0", {31'b0, mis0}, 32'h0);
`endif
    rst0 = 1'b0; rst3 = 1'b0;

    // fill the single-cycle memory with known contents
    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      model(0, i * 4, r, 3'b001, 2'b00, erd, ewb, emis);
      drive0(i * 4, r, 5'd0, 3'b001, 2'b00, 1'b0);
      @(posedge clk); #1;
    end

    // directed vectors on the single-cycle instance
    for (int i = 0; i < 10; i++) begin
      model(0, vecs[i].res, vecs[i].wd, vecs[i].m, vecs[i].wb, erd, ewb, emis);
      drive0(vecs[i].res, vecs[i].wd, vecs[i].wr, vecs[i].m, vecs[i].wb, vecs[i].z);
      #1;
      chk($sformatf("vec%0d_pc_src", i), {31'b0, pc0}, {31'b0, vecs[i].e_pc});
      @(posedge clk); #1;
      chk($sformatf("vec%0d_read_data", i), rd0, vecs[i].e_rd);
      chk($sformatf("vec%0d_wb_WB", i), {30'b0, wbwb0}, {30'b0, vecs[i].e_wb});
      chk($sformatf("vec%0d_alu_res_wb", i), alu0, vecs[i].res);
      chk($sformatf("vec%0d_wreg_wb", i), {27'b0, wrwb0}, {27'b0, vecs[i].wr});
    end

    // async reset clears a loaded MEM/WB register
    drive0('0, '0, '0, '0, '0, 1'b0);
    rst0 = 1'b1; #1;
    chk("rst_mid_rd0", rd0, 32'h0);
    chk("rst_mid_wb0", {30'b0, wbwb0}, 32'h0);
    chk("rst_mid_wreg0", {27'b0, wrwb0}, 32'h0);
    #1 rst0 = 1'b0;
    @(posedge clk); #1;

`ifdef MISALIGN_EN
    // misaligned store is dropped, misaligned load cancels its register write
    op0(32'h13, 32'hCAFEF00D, 5'd0, 3'b001, 2'b00, 1'b0);
    chk("mis_store_flag", {31'b0, mis0}, 32'h1);
    op0(32'h10, 32'h0, 5'd6, 3'b010, 2'b11, 1'b0);
    chk("mis_mem_unchanged", rd0, 32'hDEADBEEF);
    op0(32'h12, 32'h0, 5'd6, 3'b010, 2'b11, 1'b0);
    chk("mis_load_rd", rd0, 32'h0);
    chk("mis_load_regwrite", {31'b0, wbwb0[0]}, 32'h0);
`endif

    // randomized single-cycle traffic against the model
    for (int i = 0; i < 200; i++) begin
      r = $urandom;
      if ($urandom_range(0, 1) == 1) r[1:0] = 2'b00;
      op0(r, $urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    drive0('0, '0, '0, '0, '0, 1'b0);

    // fill the latency-3 memory
    for (int i = 0; i < 256; i++) txn3(i * 4, $urandom, 5'd0, 3'b001, 2'b00, 1'b0);

    // held load: three stall cycles of bubbles, data on the 4th edge
    txn3(32'h40, 32'h0, 5'd8, 3'b010, 2'b11, 1'b0);
    chk("l3_load_held_rd", rd3, ref3[16]);

    // store aborted by reset in the second wait cycle
    old = ref3[17];
    drive3(32'h44, ~old, 5'd0, 3'b001, 2'b00, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_waiting", {31'b0, st3}, 32'h1);
    rst3 = 1'b1;
    drive3('0, '0, '0, '0, '0, 1'b0);
    #1;
    chk("abort_idle_stall", {31'b0, st3}, 32'h0);
    chk("abort_rd", rd3, 32'h0);
    chk("abort_wb", {30'b0, wbwb3}, 32'h0);
    #1 rst3 = 1'b0;
    @(posedge clk); #1;
    txn3(32'h44, 32'h0, 5'd2, 3'b010, 2'b11, 1'b0);
    chk("abort_old_value", rd3, old);

    // wrap-around on the latency-3 instance
    txn3(32'h400, 32'h5A5A1234, 5'd0, 3'b001, 2'b00, 1'b0);
    txn3(32'h000, 32'h0, 5'd1, 3'b010, 2'b11, 1'b0);
    chk("l3_wrap_rd", rd3, 32'h5A5A1234);

    // randomized latency-3 transactions, back to back
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      if ($urandom_range(0, 1) == 1) r[1:0] = 2'b00;
      txn3(r, $urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
